// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch stage.
// FSM state encoding, FIFO depth and the NOP word used for fault entries.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [1:0]  FIFO_DEPTH = 2'd2;
  localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: 2-entry in-order FIFO between fetch and decode.
// Clear has priority over push and pop; the head is presented directly
// from storage so it stays stable while not popped.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers; contents reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Issues one registered word read at a
// time to instruction memory, buffers {pc, instr} in a 2-entry FIFO toward
// decode, strobes pc_adv on each accepted fetch and drops work on flush.
// Optional feature macro: IFETCH_MISALIGN_EN (misaligned PC produces a
// fault entry instead of a memory request).
module ifetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_adv,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_fault
);

`ifdef IFETCH_MISALIGN_EN
  localparam int FW = ADDR_W + DATA_W + 1;
`else
  localparam int FW = ADDR_W + DATA_W;
`endif

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              push;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] push_instr;
  logic [FW-1:0]     push_data;
  logic [FW-1:0]     head;
  logic [1:0]        count;
  logic              has_room;
  logic              misalign;

  assign has_room = (count < FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_EN
  // Gated by rst_n so pc_adv reads 0 while reset is held.
  assign misalign  = rst_n && (pc[1:0] != 2'b00);
  // Only IDLE pushes fault entries; WAIT pushes real memory data.
  assign push_data = {(state_q == IDLE), push_pc, push_instr};
  assign if_fault  = head[FW-1];
`else
  assign misalign  = 1'b0;
  assign push_data = {push_pc, push_instr};
  assign if_fault  = 1'b0;
`endif

  // Next-state, request registers, FIFO push and the pc advance strobe.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_pc    = addr_q;
    push_instr = imem_rdata;
    pc_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (has_room && !flush) begin
          if (misalign) begin
            push       = 1'b1;
            push_pc    = pc;
            push_instr = DATA_W'(NOP);
            pc_adv     = 1'b1;
          end else begin
            req_d   = 1'b1;
            addr_d  = pc;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!flush) begin
            push   = 1'b1;
            pc_adv = 1'b1;
          end
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The outstanding read must complete; its data is thrown away.
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  ifetch_fifo #(
    .WIDTH(FW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (if_valid && if_ready),
    .clear    (flush),
    .head     (head),
    .count    (count)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = (count != 2'd0);
  assign if_instr  = head[DATA_W-1:0];
  assign if_pc     = head[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a latency-programmable memory
// model and a simple pc block model (load or +4 on pc_adv).
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_adv;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  logic        pc_load;
  logic [31:0] pc_load_val;
  int          lat;
  int          wcnt;
  int          checks;
  int          errors;

  ifetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .pc_adv    (pc_adv),
    .flush     (flush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_fault  (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack after `lat` wait cycles; data derived from the address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = 32'h2408_0005 + imem_addr;

  // pc block: explicit load wins, otherwise advance by 4 on pc_adv.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_adv) pc <= pc + 32'd4;
  end

  task automatic do_reset(input logic [31:0] start_pc, input int l, input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; if_ready = rdy; lat = l;
    pc_load = 1'b1; pc_load_val = start_pc;
    @(negedge clk);
    @(negedge clk);
    pc_load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; if_ready = 1'b1; lat = 0;
    pc_load = 1'b1; pc_load_val = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", imem_addr); end
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL rst_pc_adv got %0h exp 0", pc_adv); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %0h exp 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %0h exp 0", if_pc); end
    checks++; if (if_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0h exp 0", if_fault); end
    pc_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t1_req got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL t1_addr got %0h exp 0", imem_addr); end
    checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL t1_pc_adv got %0h exp 1", pc_adv); end
    @(negedge clk);
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL t1_pc_adv_once got %0h exp 0", pc_adv); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0h exp 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL t1_if_pc got %0h exp 0", if_pc); end
    checks++; if (if_instr !== 32'h2408_0005) begin errors++; $display("FAIL t1_instr got %0h exp 24080005", if_instr); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL t1_pc got %0h exp 4", pc); end
  endtask

  task automatic test_backpressure;
    do_reset(32'h100, 0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0h exp 1", if_valid); end
    checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL bp_head_pc got %0h exp 100", if_pc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req cyc %0d got %0h exp 0", i, imem_req); end
    end
    checks++; if (pc !== 32'h108) begin errors++; $display("FAIL bp_pc got %0h exp 108", pc); end
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_pc !== 32'h104) begin errors++; $display("FAIL bp_drain_pc got %0h exp 104", if_pc); end
    checks++; if (if_instr !== 32'h2408_0109) begin errors++; $display("FAIL bp_drain_instr got %0h exp 24080109", if_instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_drain_req got %0h exp 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL bp_resume_addr got %0h exp 108", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0h exp 0", if_valid); end
    if_ready = 1'b0;
  endtask

  task automatic test_flush_drop;
    do_reset(32'h200, 3, 1'b1);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin errors++; $display("FAIL fd_req_ack got %0h/%0h exp 1/0", imem_req, imem_ack); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL fd_flush_adv got %0h exp 0", pc_adv); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fd_hold_req got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL fd_hold_addr got %0h exp 200", imem_addr); end
    @(negedge clk);
    checks++; if (imem_ack !== 1'b1) begin errors++; $display("FAIL fd_ack got %0h exp 1", imem_ack); end
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL fd_drop_adv got %0h exp 0", pc_adv); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fd_req_clr got %0h exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fd_valid got %0h exp 0", if_valid); end
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL fd_pc got %0h exp 200", pc); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL fd_reissue got %0h/%0h exp 1/200", imem_req, imem_addr); end
  endtask

  task automatic test_flush_ack_pop;
    do_reset(32'h300, 0, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (if_valid !== 1'b1 || imem_ack !== 1'b1) begin errors++; $display("FAIL fa_setup got %0h/%0h exp 1/1", if_valid, imem_ack); end
    if_ready = 1'b1; flush = 1'b1;
    pc_load = 1'b1; pc_load_val = 32'h500;
    #1;
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL fa_adv got %0h exp 0", pc_adv); end
    @(negedge clk);
    flush = 1'b0; if_ready = 1'b0; pc_load = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fa_empty got %0h exp 0", if_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fa_req got %0h exp 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fa_redir_req got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h500) begin errors++; $display("FAIL fa_redir_addr got %0h exp 500", imem_addr); end
  endtask

  task automatic test_async_reset;
    bit seen;
    do_reset(32'h400, 3, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h400) begin errors++; $display("FAIL ar_first got %0h/%0h exp 1/400", if_valid, if_pc); end
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin errors++; $display("FAIL ar_wait got %0h/%0h exp 1/404", imem_req, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req got %0h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr got %0h exp 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %0h exp 0", if_valid); end
    checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL ar_head got %0h/%0h exp 0/0", if_instr, if_pc); end
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL ar_adv got %0h exp 0", pc_adv); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin errors++; $display("FAIL ar_restart got %0h/%0h exp 1/404", imem_req, imem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL ar_timeout got if_valid %0h exp 1", if_valid); end
    checks++; if (if_pc !== 32'h404 || if_instr !== 32'h2408_0409) begin errors++; $display("FAIL ar_entry got %0h/%0h exp 404/24080409", if_pc, if_instr); end
  endtask

  task automatic test_misalign;
    do_reset(32'h102, 0, 1'b0);
`ifdef IFETCH_MISALIGN_EN
    #1;
    checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL ma_adv got %0h exp 1", pc_adv); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ma_req got %0h exp 0", imem_req); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h102) begin errors++; $display("FAIL ma_entry got %0h/%0h exp 1/102", if_valid, if_pc); end
    checks++; if (if_instr !== 32'h0 || if_fault !== 1'b1) begin errors++; $display("FAIL ma_fault got %0h/%0h exp 0/1", if_instr, if_fault); end
`else
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h102) begin errors++; $display("FAIL ma_issue got %0h/%0h exp 1/102", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_fault !== 1'b0) begin errors++; $display("FAIL ma_nofault got %0h/%0h exp 1/0", if_valid, if_fault); end
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; if_ready = 1'b0; lat = 0;
    pc_load = 1'b1; pc_load_val = 32'h0;
    test_reset();
    test_backpressure();
    test_flush_drop();
    test_flush_ack_pop();
    test_async_reset();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
